// File: rtl/audio_lj_pkg.sv
// Shared definitions for the left-justified audio codec paths (DAC playback and ADC capture).
package audio_lj_pkg;

  localparam logic LRC_LEFT  = 1'b0;
  localparam logic LRC_RIGHT = 1'b1;

  typedef enum logic {IDLE, RUN} lj_state_t;

  // Bit counter spans one full frame of two channels.
  function automatic int lj_cnt_width(input int data_width);
    return $clog2(2 * data_width);
  endfunction

endpackage

// File: rtl/lj_piso.sv
// Parallel-load, MSB-first shift register; msb_nxt_o is the MSB it will hold after this edge,
// so the caller can register serial data without an extra cycle of latency.
module lj_piso #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  msb_nxt_o
);

  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {data_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    msb_nxt_o = data_q[DATA_WIDTH-1];
    if (load_i) begin
      msb_nxt_o = data_i[DATA_WIDTH-1];
    end else if (shift_i) begin
      msb_nxt_o = data_q[DATA_WIDTH-2];
    end
  end

endmodule

// File: rtl/out_lj.sv
// Left-justified DAC transmitter: one-deep sample-pair buffer feeding two shift registers.
// Gap-free frames of 2*DATA_WIDTH BCLKs; an empty buffer at a frame boundary sends zeros and flags underrun.
module out_lj
  import audio_lj_pkg::*;
#(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  BCLK,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  load,
  output logic                  ready,
  output logic                  DACLRC,
  output logic                  DACDAT,
  output logic                  frame_start,
  output logic                  busy,
  output logic                  underrun,
  input  logic                  clear_underrun
);

  localparam int              CW   = lj_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(2 * DATA_WIDTH - 1);
  localparam logic [CW-1:0]   HALF = CW'(DATA_WIDTH - 1);

  lj_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dat_q, dat_d;
  logic                  lrc_q, lrc_d;
  logic                  fs_q, fs_d;
  logic                  urun_q;
  logic                  full_q;
  logic [DATA_WIDTH-1:0] buf_l_q, buf_r_q;

  logic                  xfer, urun_set, shift_l, shift_r;
  logic                  l_msb_nxt, r_msb_nxt;
  logic [DATA_WIDTH-1:0] xfer_l, xfer_r;

  // An empty buffer at transfer time loads zeros, which is how the underrun frame is produced.
  assign xfer_l = full_q ? buf_l_q : '0;
  assign xfer_r = full_q ? buf_r_q : '0;

  lj_piso #(.DATA_WIDTH(DATA_WIDTH)) u_piso_l (
    .clk_i     (BCLK),
    .rst_i     (reset),
    .load_i    (xfer),
    .shift_i   (shift_l),
    .data_i    (xfer_l),
    .msb_nxt_o (l_msb_nxt)
  );

  lj_piso #(.DATA_WIDTH(DATA_WIDTH)) u_piso_r (
    .clk_i     (BCLK),
    .rst_i     (reset),
    .load_i    (xfer),
    .shift_i   (shift_r),
    .data_i    (xfer_r),
    .msb_nxt_o (r_msb_nxt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dat_d    = 1'b0;
    lrc_d    = LRC_LEFT;
    fs_d     = 1'b0;
    xfer     = 1'b0;
    urun_set = 1'b0;
    shift_l  = 1'b0;
    shift_r  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && full_q) begin
          xfer    = 1'b1;
          state_d = RUN;
          cnt_d   = '0;
          dat_d   = l_msb_nxt;
          fs_d    = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!enable) begin
            state_d = IDLE;
          end else begin
            xfer     = 1'b1;
            urun_set = !full_q;
            dat_d    = l_msb_nxt;
            fs_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q < HALF) begin
            shift_l = 1'b1;
            dat_d   = l_msb_nxt;
          end else begin
            // Right register is left unshifted on the first right-half cycle so its MSB goes out.
            shift_r = (cnt_q != HALF);
            dat_d   = r_msb_nxt;
            lrc_d   = LRC_RIGHT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BCLK) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dat_q   <= 1'b0;
      lrc_q   <= LRC_LEFT;
      fs_q    <= 1'b0;
      urun_q  <= 1'b0;
      full_q  <= 1'b0;
      buf_l_q <= '0;
      buf_r_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      lrc_q   <= lrc_d;
      fs_q    <= fs_d;
      if (urun_set) begin
        urun_q <= 1'b1;
      end else if (clear_underrun) begin
        urun_q <= 1'b0;
      end
      if (load && !full_q) begin
        full_q  <= 1'b1;
        buf_l_q <= left_in;
        buf_r_q <= right_in;
      end else if (xfer && full_q) begin
        full_q <= 1'b0;
      end
    end
  end

  assign ready       = !full_q;
  assign DACLRC      = lrc_q;
  assign DACDAT      = dat_q;
  assign frame_start = fs_q;
  assign busy        = (state_q == RUN);
  assign underrun    = urun_q;

endmodule

// File: tb/tb_out_lj.sv
// Directed bench for out_lj at DATA_WIDTH=24: captures whole frames and compares against hand-written pairs.
module tb_out_lj;

  logic        bclk;
  logic        reset;
  logic        enable;
  logic [23:0] left_in;
  logic [23:0] right_in;
  logic        load;
  logic        ready;
  logic        DACLRC;
  logic        DACDAT;
  logic        frame_start;
  logic        busy;
  logic        underrun;
  logic        clear_underrun;

  int n_total = 0;
  int n_pass  = 0;

  logic [47:0] dat, lrc, fsv;

  out_lj #(.DATA_WIDTH(24)) dut (
    .BCLK           (bclk),
    .reset          (reset),
    .enable         (enable),
    .left_in        (left_in),
    .right_in       (right_in),
    .load           (load),
    .ready          (ready),
    .DACLRC         (DACLRC),
    .DACDAT         (DACDAT),
    .frame_start    (frame_start),
    .busy           (busy),
    .underrun       (underrun),
    .clear_underrun (clear_underrun)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Observe one 48-cycle frame starting at the current cycle, optionally poking inputs at given steps.
  task automatic run_frame(input int ld_at, input logic [23:0] l, input logic [23:0] r,
                           input int ld2_at, input logic [23:0] l2, input logic [23:0] r2,
                           input int en_off_at, input int clr_at,
                           output logic [47:0] d, output logic [47:0] c, output logic [47:0] f);
    for (int i = 0; i < 48; i++) begin
      d[47-i] = DACDAT;
      c[47-i] = DACLRC;
      f[47-i] = frame_start;
      load           = 1'b0;
      clear_underrun = 1'b0;
      if (i == ld_at) begin
        load = 1'b1; left_in = l; right_in = r;
      end
      if (i == ld2_at) begin
        load = 1'b1; left_in = l2; right_in = r2;
      end
      if (i == en_off_at) enable = 1'b0;
      if (i == clr_at) clear_underrun = 1'b1;
      tick();
    end
    load           = 1'b0;
    clear_underrun = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [23:0] l, input logic [23:0] r);
    chk({tag, ".dacdat"}, 64'(dat), 64'({l, r}));
    chk({tag, ".daclrc"}, 64'(lrc), 64'h0000_0000_00FF_FFFF);
    chk({tag, ".fstart"}, 64'(fsv), 64'h0000_8000_0000_0000);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; clear_underrun = 1'b0;
    left_in = 24'h0; right_in = 24'h0;
    tick();
    tick();
    chk("rst.daclrc", 64'(DACLRC), 64'd0);
    chk("rst.dacdat", 64'(DACDAT), 64'd0);
    chk("rst.ready", 64'(ready), 64'd1);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.fstart", 64'(frame_start), 64'd0);
    chk("rst.underrun", 64'(underrun), 64'd0);
    reset = 1'b0;

    // Basic frame
    left_in = 24'hA5F00F; right_in = 24'h123456; load = 1'b1;
    tick();
    load = 1'b0;
    chk("load.ready", 64'(ready), 64'd0);
    chk("idle.busy", 64'(busy), 64'd0);
    enable = 1'b1;
    tick();
    chk("start.fstart", 64'(frame_start), 64'd1);
    chk("start.busy", 64'(busy), 64'd1);
    chk("start.ready", 64'(ready), 64'd1);
    run_frame(-1, 24'h0, 24'h0, -1, 24'h0, 24'h0, -1, -1, dat, lrc, fsv);
    check_frame("basic", 24'hA5F00F, 24'h123456);

    // Underrun: two zero frames, clear, then resume
    chk("ur.flag", 64'(underrun), 64'd1);
    run_frame(-1, 24'h0, 24'h0, -1, 24'h0, 24'h0, -1, -1, dat, lrc, fsv);
    check_frame("ur_zero1", 24'h0, 24'h0);
    chk("ur.sticky", 64'(underrun), 64'd1);
    run_frame(10, 24'h800001, 24'h7FFFFE, -1, 24'h0, 24'h0, -1, 5, dat, lrc, fsv);
    check_frame("ur_zero2", 24'h0, 24'h0);
    chk("ur.cleared", 64'(underrun), 64'd0);

    // Back-to-back streaming
    run_frame(5, 24'hC3C3C3, 24'h3C3C3C, -1, 24'h0, 24'h0, -1, -1, dat, lrc, fsv);
    check_frame("b2b1", 24'h800001, 24'h7FFFFE);
    run_frame(30, 24'h000001, 24'h800000, -1, 24'h0, 24'h0, -1, -1, dat, lrc, fsv);
    check_frame("b2b2", 24'hC3C3C3, 24'h3C3C3C);
    run_frame(39, 24'hDEADBE, 24'hEF0123, -1, 24'h0, 24'h0, -1, -1, dat, lrc, fsv);
    check_frame("b2b3", 24'h000001, 24'h800000);
    run_frame(3, 24'h111111, 24'h222222, 8, 24'hFFFFFF, 24'hFFFFFF, -1, -1, dat, lrc, fsv);
    check_frame("b2b4", 24'hDEADBE, 24'hEF0123);
    chk("b2b.underrun", 64'(underrun), 64'd0);

    // Handshake protection, with enable dropped at c=10 of this frame
    run_frame(2, 24'hABCDEF, 24'hFEDCBA, -1, 24'h0, 24'h0, 10, -1, dat, lrc, fsv);
    check_frame("hs", 24'h111111, 24'h222222);
    chk("stop.busy", 64'(busy), 64'd0);
    chk("stop.dacdat", 64'(DACDAT), 64'd0);
    chk("stop.daclrc", 64'(DACLRC), 64'd0);
    chk("stop.fstart", 64'(frame_start), 64'd0);
    chk("stop.ready", 64'(ready), 64'd0);
    tick();
    tick();
    chk("stop.hold_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    tick();
    chk("restart.fstart", 64'(frame_start), 64'd1);
    run_frame(-1, 24'h0, 24'h0, -1, 24'h0, 24'h0, -1, -1, dat, lrc, fsv);
    check_frame("retained", 24'hABCDEF, 24'hFEDCBA);
    chk("ur2.flag", 64'(underrun), 64'd1);

    // Reset at c=30 of an underrun frame with a pair waiting in the buffer
    left_in = 24'h555555; right_in = 24'hAAAAAA;
    for (int i = 0; i < 30; i++) begin
      load = (i == 5);
      tick();
    end
    load = 1'b0;
    chk("pre_rst.daclrc", 64'(DACLRC), 64'd1);
    chk("pre_rst.busy", 64'(busy), 64'd1);
    chk("pre_rst.ready", 64'(ready), 64'd0);
    chk("pre_rst.underrun", 64'(underrun), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst.daclrc", 64'(DACLRC), 64'd0);
    chk("mid_rst.dacdat", 64'(DACDAT), 64'd0);
    chk("mid_rst.ready", 64'(ready), 64'd1);
    chk("mid_rst.busy", 64'(busy), 64'd0);
    chk("mid_rst.underrun", 64'(underrun), 64'd0);
    chk("mid_rst.fstart", 64'(frame_start), 64'd0);
    tick();
    tick();
    chk("post_rst.busy", 64'(busy), 64'd0);
    enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
